// File: rtl/matmul_ctrl_pkg.sv
// matmul_ctrl_pkg: definitions shared by the matmul control blocks.
// Contents: array geometry (ROWS), the input-control FSM state type and a
//   helper that sizes counters so they can reach their terminal value without wrapping.
package matmul_ctrl_pkg;

  // Systolic array geometry: one input lane per row.
  localparam int ROWS = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    STREAM,
    DRAIN,
    DONE
  } in_ctrl_state_t;

  // $clog2(n)+1 bits: one spare bit so a count of n-1 never wraps before its compare.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/input_skew_delay.sv
// input_skew_delay: enable-gated shift register that delays one lane by DEPTH clks.
// Ports: i_clk, i_rst (async, active-high), i_en (shift when high),
//   i_dat -> o_dat. DEPTH=0 is a pure wire, so lane 0 adds no latency.
module input_skew_delay #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_dat,
  output logic [WIDTH-1:0] o_dat
);

  if (DEPTH == 0) begin : g_pass
    // Clock, reset and enable have no role in the pass-through case.
    logic w_unused;
    assign w_unused = i_clk ^ i_rst ^ i_en;
    assign o_dat    = i_dat;
  end else begin : g_shift
    logic [DEPTH-1:0][WIDTH-1:0] r_sr;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_sr <= '0;
      end else if (i_en) begin
        r_sr[0] <= i_dat;
        for (int i = 1; i < DEPTH; i++) begin
          r_sr[i] <= r_sr[i-1];
        end
      end
    end

    assign o_dat = r_sr[DEPTH-1];
  end

endmodule

// File: rtl/matmul_input_control.sv
// matmul_input_control: latches an input matrix and streams it into the systolic
// array row lanes. Lane r is skewed r clks behind lane 0; each element is held
// HOLD_CYCLES clks.
// Ports: i_clk, i_rst (async, active-high), i_start, i_stall (global freeze),
//   i_input_matrix[k][r]; o_matmul_fsm_input (lane r at r*WORD_SIZE),
//   o_matmul_input_valid (per lane), o_busy, o_done (1-clk pulse, held during stall).
module matmul_input_control
  import matmul_ctrl_pkg::*;
#(
  parameter int WORD_SIZE   = 16,
  parameter int N_VEC       = ROWS,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst,
  input  logic                                      i_start,
  input  logic                                      i_stall,
  input  logic [N_VEC-1:0][ROWS-1:0][WORD_SIZE-1:0] i_input_matrix,
  output logic [ROWS*WORD_SIZE-1:0]                 o_matmul_fsm_input,
  output logic [ROWS-1:0]                           o_matmul_input_valid,
  output logic                                      o_busy,
  output logic                                      o_done
);

  localparam int VK_W = cnt_width(N_VEC);
  localparam int HC_W = cnt_width(HOLD_CYCLES);
  localparam int DR_W = cnt_width(ROWS);
  localparam int VI_W = (N_VEC > 1) ? $clog2(N_VEC) : 1;

  localparam logic [VK_W-1:0] VK_LAST = VK_W'(N_VEC - 1);
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(HOLD_CYCLES - 1);
  // DRAIN lasts ROWS-1 clks, so the drain counter stops at ROWS-2.
  localparam logic [DR_W-1:0] DR_LAST = DR_W'((ROWS > 1) ? ROWS - 2 : 0);

  in_ctrl_state_t                           r_state;
  logic [VK_W-1:0]                          r_vk;
  logic [HC_W-1:0]                          r_hc;
  logic [DR_W-1:0]                          r_drain;
  logic                                     r_pend;
  logic                                     r_busy;
  logic                                     r_done;
  logic [ROWS-1:0]                          r_lane_vld;
  logic [ROWS-1:0][WORD_SIZE-1:0]           r_lane_dat;
  logic [N_VEC-1:0][ROWS-1:0][WORD_SIZE-1:0] r_buf;

  logic w_accept;
  logic w_en;

  // A start seen in IDLE is taken exactly once; r_pend remembers it if a stall
  // holds the FSM, so later matrix changes cannot overwrite the captured one.
  assign w_accept = (r_state == IDLE) && i_start && !r_pend;
  assign w_en     = ~i_stall;

  // Buffer contents are don't-care out of reset, so no reset term here.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_buf <= i_input_matrix;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_vk       <= '0;
      r_hc       <= '0;
      r_drain    <= '0;
      r_pend     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_lane_vld <= '0;
      r_lane_dat <= '0;
    end else if (i_stall) begin
      // Everything freezes; only the start request is remembered.
      if (w_accept) begin
        r_pend <= 1'b1;
      end
    end else begin
      // Outputs follow the current state, so they trail the state by one clk.
      r_busy <= (r_state == LOAD) || (r_state == STREAM) || (r_state == DRAIN);
      r_done <= (r_state == DONE);
      for (int r = 0; r < ROWS; r++) begin
        r_lane_vld[r] <= (r_state == STREAM);
        r_lane_dat[r] <= (r_state == STREAM) ? r_buf[r_vk[VI_W-1:0]][r] : '0;
      end

      case (r_state)
        IDLE: begin
          if (i_start || r_pend) begin
            r_state <= LOAD;
            r_pend  <= 1'b0;
          end
        end
        LOAD: begin
          r_state <= STREAM;
          r_vk    <= '0;
          r_hc    <= '0;
        end
        STREAM: begin
          if (r_hc == HC_LAST) begin
            r_hc <= '0;
            if (r_vk == VK_LAST) begin
              r_vk    <= '0;
              r_drain <= '0;
              r_state <= (ROWS > 1) ? DRAIN : DONE;
            end else begin
              r_vk <= r_vk + 1'b1;
            end
          end else begin
            r_hc <= r_hc + 1'b1;
          end
        end
        DRAIN: begin
          if (r_drain == DR_LAST) begin
            r_drain <= '0;
            r_state <= DONE;
          end else begin
            r_drain <= r_drain + 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Each lane carries {valid, data} through its own skew line.
  for (genvar gr = 0; gr < ROWS; gr++) begin : g_lane
    logic [WORD_SIZE:0] w_skew_out;

    input_skew_delay #(
      .WIDTH(WORD_SIZE + 1),
      .DEPTH(gr)
    ) u_skew (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .i_en (w_en),
      .i_dat({r_lane_vld[gr], r_lane_dat[gr]}),
      .o_dat(w_skew_out)
    );

    assign o_matmul_input_valid[gr]                      = w_skew_out[WORD_SIZE];
    assign o_matmul_fsm_input[gr*WORD_SIZE +: WORD_SIZE] = w_skew_out[WORD_SIZE-1:0];
  end

  assign o_busy = r_busy;
  assign o_done = r_done;

endmodule

// File: tb/tb_matmul_input_control.sv
// Bench for matmul_input_control: stimulus pushes expected (cycle, value)
// entries for every lane, busy and done; a negedge monitor pops and compares.
module tb_matmul_input_control;
  import matmul_ctrl_pkg::*;

  localparam int W  = 16;
  localparam int NV = 4;
  localparam int H  = 2;
  localparam int R  = ROWS;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic stall;
  logic [NV-1:0][R-1:0][W-1:0] mat;
  logic [NV-1:0][R-1:0][W-1:0] mat_a;
  logic [NV-1:0][R-1:0][W-1:0] mat_f;
  logic [R*W-1:0] lanes;
  logic [R-1:0]   vld;
  logic busy;
  logic done;

  int cyc    = 0;
  int n_chk  = 0;
  int n_fail = 0;

  logic [47:0] q_lane [R][$];
  int          q_busy [$];
  int          q_done [$];

  matmul_input_control #(
    .WORD_SIZE  (W),
    .N_VEC      (NV),
    .HOLD_CYCLES(H)
  ) dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_start             (start),
    .i_stall             (stall),
    .i_input_matrix      (mat),
    .o_matmul_fsm_input  (lanes),
    .o_matmul_input_valid(vld),
    .o_busy              (busy),
    .o_done              (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Expected outputs for a stream whose start is sampled at edge e0, with a
  // stall sampled at edges s..s+l-1 and a reset landing just after edge cut.
  // Actual edge a shows what an unstalled run would show after edge n.
  task automatic push_stream(input int e0, input logic [NV-1:0][R-1:0][W-1:0] m,
                             input int s, input int l, input int cut);
    for (int a = e0; a < e0 + 24 + l; a++) begin
      int n;
      if (a >= cut) break;
      n = (l == 0 || a < s) ? a : ((a < s + l) ? s - 1 : a - l);
      for (int r = 0; r < R; r++) begin
        int i;
        i = n - (e0 + 2 + r);
        if (i >= 0 && i < NV * H) q_lane[r].push_back({32'(a), m[i / H][r]});
      end
      if (n >= e0 + 1 && n <= e0 + 12) q_busy.push_back(a);
      if (n == e0 + 13) q_done.push_back(a);
    end
  endtask

  function automatic int pending();
    int t;
    t = q_busy.size() + q_done.size();
    for (int r = 0; r < R; r++) t += q_lane[r].size();
    return t;
  endfunction

  // Monitor: compares every cycle, away from the rising edge.
  always @(negedge clk) begin
    for (int r = 0; r < R; r++) begin
      logic [W-1:0] d;
      logic [47:0]  e;
      d = lanes[r*W +: W];
      if (vld[r]) begin
        if (q_lane[r].size() == 0) begin
          chk(1'b0, $sformatf("lane%0d unexpected valid", r), d, 0);
        end else begin
          e = q_lane[r].pop_front();
          chk(int'(e[47:16]) == cyc, $sformatf("lane%0d valid cycle", r), cyc, int'(e[47:16]));
          chk(e[15:0] == d, $sformatf("lane%0d data", r), d, e[15:0]);
        end
      end else begin
        chk(d == '0, $sformatf("lane%0d idle data zero", r), d, 0);
        if (q_lane[r].size() != 0 && int'(q_lane[r][0][47:16]) == cyc) begin
          e = q_lane[r].pop_front();
          chk(1'b0, $sformatf("lane%0d missing valid", r), 0, e[15:0]);
        end
      end
    end
    if (busy) begin
      int eb;
      if (q_busy.size() == 0) chk(1'b0, "busy unexpected", 1, 0);
      else begin
        eb = q_busy.pop_front();
        chk(eb == cyc, "busy cycle", cyc, eb);
      end
    end else if (q_busy.size() != 0 && q_busy[0] == cyc) begin
      int eb;
      eb = q_busy.pop_front();
      chk(1'b0, "busy missing", 0, 1);
    end
    if (done) begin
      int ed;
      if (q_done.size() == 0) chk(1'b0, "done unexpected", 1, 0);
      else begin
        ed = q_done.pop_front();
        chk(ed == cyc, "done cycle", cyc, ed);
      end
    end else if (q_done.size() != 0 && q_done[0] == cyc) begin
      int ed;
      ed = q_done.pop_front();
      chk(1'b0, "done missing", 0, 1);
    end
  end

  task automatic chk_quiet(input string tag);
    chk(vld == '0,   {tag, " valid"}, vld, 0);
    chk(lanes == '0, {tag, " data"}, lanes, 0);
    chk(busy == 1'b0, {tag, " busy"}, busy, 0);
    chk(done == 1'b0, {tag, " done"}, done, 0);
  endtask

  task automatic wait_drain(input string tag);
    int guard;
    guard = 0;
    while (pending() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk(guard < 100, {tag, " drained within budget"}, guard, 100);
    repeat (3) @(negedge clk);
  endtask

  task automatic kick(input logic [NV-1:0][R-1:0][W-1:0] m, output int e0);
    mat   = m;
    e0    = cyc + 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int e1;
    for (int k = 0; k < NV; k++) begin
      for (int r = 0; r < R; r++) begin
        mat_a[k][r] = 16'(16 * k + r);
        mat_f[k][r] = 16'hFFFF;
      end
    end
    rst   = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    mat   = mat_a;

    // 1: reset state, then idle
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk_quiet("idle");

    // 2: basic stream
    kick(mat_a, e0);
    push_stream(e0, mat_a, 0, 0, 1 << 30);
    wait_drain("basic");

    // 3: three-clk stall sampled at edges e0+4..e0+6
    kick(mat_a, e0);
    push_stream(e0, mat_a, e0 + 4, 3, 1 << 30);
    while (cyc < e0 + 3) @(negedge clk);
    stall = 1'b1;
    repeat (3) @(negedge clk);
    stall = 1'b0;
    wait_drain("stall");

    // 4: start and new matrix mid-stream are ignored; next run picks them up
    kick(mat_a, e0);
    push_stream(e0, mat_a, 0, 0, 1 << 30);
    mat = mat_f;
    while (cyc < e0 + 4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain("ignore start");
    kick(mat_f, e1);
    push_stream(e1, mat_f, 0, 0, 1 << 30);
    wait_drain("second stream");

    // 5: asynchronous reset just after edge e0+7
    kick(mat_a, e0);
    push_stream(e0, mat_a, 0, 0, e0 + 7);
    while (cyc < e0 + 6) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_quiet("async reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_drain("reset cut");
    kick(mat_a, e0);
    push_stream(e0, mat_a, 0, 0, 1 << 30);
    wait_drain("after reset");

    // 6: start with stall from IDLE for two clks
    mat   = mat_a;
    e0    = cyc + 1;
    start = 1'b1;
    stall = 1'b1;
    push_stream(e0 + 2, mat_a, 0, 0, 1 << 30);
    repeat (2) @(negedge clk);
    start = 1'b0;
    stall = 1'b0;
    wait_drain("start under stall");

    chk_quiet("final idle");
    for (int r = 0; r < R; r++) begin
      chk(q_lane[r].size() == 0, $sformatf("lane%0d queue empty", r), q_lane[r].size(), 0);
    end
    chk(q_busy.size() == 0, "busy queue empty", q_busy.size(), 0);
    chk(q_done.size() == 0, "done queue empty", q_done.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
